// File: rtl/ff_pkt_arbiter_if.sv
// Bus bundle for ff_pkt_arbiter: ingress streams, first_filter feed, metadata and credits.
// The arbiter takes the slave view; the environment driving ingress takes the master view.
interface ff_pkt_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int FP_DWIDTH = 128,
    parameter int FP_EWIDTH = 4
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS*FP_DWIDTH-1:0] s_data;
    logic [NUM_PORTS-1:0]           s_valid;
    logic [NUM_PORTS-1:0]           s_sop;
    logic [NUM_PORTS-1:0]           s_eop;
    logic [NUM_PORTS*FP_EWIDTH-1:0] s_empty;
    logic [NUM_PORTS-1:0]           s_ready;
    logic [FP_DWIDTH-1:0]           ff_data;
    logic                           ff_valid;
    logic                           ff_sop;
    logic                           ff_eop;
    logic [FP_EWIDTH-1:0]           ff_empty;
    logic                           meta_valid;
    logic [PW-1:0]                  meta_port;
    logic                           meta_sop;
    logic                           meta_eop;
    logic [FP_EWIDTH-1:0]           meta_empty;
    logic                           credit_return;
    logic                           credit_err;

    modport slave (
        input  s_data, s_valid, s_sop, s_eop, s_empty, credit_return,
        output s_ready, ff_data, ff_valid, ff_sop, ff_eop, ff_empty,
        output meta_valid, meta_port, meta_sop, meta_eop, meta_empty, credit_err
    );

    modport master (
        output s_data, s_valid, s_sop, s_eop, s_empty, credit_return,
        input  s_ready, ff_data, ff_valid, ff_sop, ff_eop, ff_empty,
        input  meta_valid, meta_port, meta_sop, meta_eop, meta_empty, credit_err
    );
endinterface

// File: rtl/ff_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one first_filter, with credit metering,
// an inter-packet idle gap and per-word metadata delay-matched to the filter output.
module ff_pkt_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int FP_DWIDTH  = 128,
    parameter int FP_EWIDTH  = 4,
    parameter int FF_LATENCY = 2,
    parameter int GAP        = 2,
    parameter int CREDITS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    ff_pkt_arbiter_if.slave   bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam int MW = 3 + PW + FP_EWIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_reg, state_next;
    logic [PW-1:0]        grant_reg, grant_next;
    logic [PW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [GW-1:0]        gap_cnt_reg, gap_cnt_next;
    logic [CW-1:0]        credits_reg, credits_next;
    logic                 credit_err_reg, credit_err_next;

    logic [FP_DWIDTH-1:0] ff_data_reg;
    logic                 ff_valid_reg, ff_sop_reg, ff_eop_reg;
    logic [FP_EWIDTH-1:0] ff_empty_reg;
    logic [MW-1:0]        meta_pipe_reg [FF_LATENCY];

    logic [FP_DWIDTH-1:0] port_data  [NUM_PORTS];
    logic [FP_EWIDTH-1:0] port_empty [NUM_PORTS];
    logic [NUM_PORTS-1:0] s_ready_w;
    logic [NUM_PORTS-1:0] sop_req;
    logic [PW-1:0]        cand;
    logic [PW-1:0]        pick_port;
    logic                 pick_found;
    logic                 xfer;
    logic                 sel_sop, sel_eop;

    assign sop_req = bus.s_valid & bus.s_sop;

    // Per-port slicing and ready: only the granted port may move, and only with credit.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_data[gi]  = bus.s_data[gi*FP_DWIDTH +: FP_DWIDTH];
        assign port_empty[gi] = bus.s_empty[gi*FP_EWIDTH +: FP_EWIDTH];
        assign s_ready_w[gi]  = (state_reg == BUSY) && (grant_reg == PW'(gi)) &&
                                (credits_reg != '0);
    end

    // Output comb: transfer detection and the granted port's word.
    always_comb begin
        xfer    = |(bus.s_valid & s_ready_w);
        sel_sop = bus.s_sop[grant_reg];
        sel_eop = bus.s_eop[grant_reg];
    end

    // Round-robin pick among ports presenting a sop word, starting at rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_port  = '0;
        cand       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_ptr_reg) + i) % NUM_PORTS);
            if (!pick_found && sop_req[cand]) begin
                pick_found = 1'b1;
                pick_port  = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - GW'(1);
                end else if (pick_found) begin
                    grant_next = pick_port;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (xfer && sel_eop) begin
                    rr_ptr_next  = (grant_reg == PW'(NUM_PORTS - 1)) ? '0 : grant_reg + PW'(1);
                    gap_cnt_next = GW'(GAP);
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A simultaneous transfer and return cancel; a return into a full counter is an error.
    always_comb begin
        credits_next    = credits_reg;
        credit_err_next = credit_err_reg;
        if (xfer && !bus.credit_return) begin
            credits_next = credits_reg - CW'(1);
        end else if (!xfer && bus.credit_return) begin
            if (credits_reg == CW'(CREDITS)) begin
                credit_err_next = 1'b1;
            end else begin
                credits_next = credits_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            gap_cnt_reg    <= '0;
            credits_reg    <= CW'(CREDITS);
            credit_err_reg <= 1'b0;
            ff_data_reg    <= '0;
            ff_valid_reg   <= 1'b0;
            ff_sop_reg     <= 1'b0;
            ff_eop_reg     <= 1'b0;
            ff_empty_reg   <= '0;
            for (int i = 0; i < FF_LATENCY; i++) begin
                meta_pipe_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            gap_cnt_reg    <= gap_cnt_next;
            credits_reg    <= credits_next;
            credit_err_reg <= credit_err_next;
            ff_valid_reg   <= xfer;
            if (xfer) begin
                ff_data_reg  <= port_data[grant_reg];
                ff_sop_reg   <= sel_sop;
                ff_eop_reg   <= sel_eop;
                ff_empty_reg <= port_empty[grant_reg];
            end
            // grant_reg still names the source port while its last word sits in ff_*.
            meta_pipe_reg[0] <= {ff_valid_reg, grant_reg, ff_sop_reg, ff_eop_reg, ff_empty_reg};
            for (int i = 1; i < FF_LATENCY; i++) begin
                meta_pipe_reg[i] <= meta_pipe_reg[i-1];
            end
        end
    end

    assign bus.s_ready    = s_ready_w;
    assign bus.ff_data    = ff_data_reg;
    assign bus.ff_valid   = ff_valid_reg;
    assign bus.ff_sop     = ff_sop_reg;
    assign bus.ff_eop     = ff_eop_reg;
    assign bus.ff_empty   = ff_empty_reg;
    assign bus.credit_err = credit_err_reg;
    assign {bus.meta_valid, bus.meta_port, bus.meta_sop, bus.meta_eop, bus.meta_empty} =
        meta_pipe_reg[FF_LATENCY-1];
endmodule

// File: tb/tb_ff_pkt_arbiter.sv
// Scoreboard bench for ff_pkt_arbiter: per-port packet sources, expected ff/meta queues
// filled on accepted words, plus cycle-accurate checks of grant, gap and credit behaviour.
module tb_ff_pkt_arbiter;
    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int EW  = 4;
    localparam int LAT = 2;
    localparam int CR  = 4;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  empty;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ff_pkt_arbiter_if #(.NUM_PORTS(NP), .FP_DWIDTH(DW), .FP_EWIDTH(EW)) bus ();

    ff_pkt_arbiter #(
        .NUM_PORTS(NP), .FP_DWIDTH(DW), .FP_EWIDTH(EW),
        .FF_LATENCY(LAT), .GAP(2), .CREDITS(CR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t src[$];
    word_t exp_ff[$];
    word_t exp_meta[$];
    int    ff_cyc[$];
    int    meta_cyc[$];
    int    sop_log[$];
    logic [NP-1:0] rdy_log[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cycle = 0;
    int    xfer_cnt = 0;
    logic  cr = 1'b0;
    logic  auto_ret = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic add_pkt(input int port, input int n, input logic [31:0] base);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.port  = port;
            w.data  = base + 32'(i);
            w.sop   = (i == 0);
            w.eop   = (i == n - 1);
            w.empty = w.eop ? base[3:0] ^ 4'h5 : 4'h0;
            src.push_back(w);
        end
    endtask

    function automatic int head_idx(input int port);
        for (int i = 0; i < src.size(); i++)
            if (src[i].port == port) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        ff_cyc.delete(); meta_cyc.delete(); sop_log.delete(); xfer_cnt = 0;
    endtask

    task automatic tick();
        logic [NP-1:0] acc;
        int hi;
        word_t w;
        bus.credit_return = cr | (auto_ret & bus.ff_valid);
        for (int p = 0; p < NP; p++) begin
            hi = head_idx(p);
            bus.s_valid[p] = (hi >= 0);
            if (hi >= 0) begin
                bus.s_data[p*DW +: DW]  = src[hi].data;
                bus.s_sop[p]            = src[hi].sop;
                bus.s_eop[p]            = src[hi].eop;
                bus.s_empty[p*EW +: EW] = src[hi].empty;
            end else begin
                bus.s_sop[p] = 1'b0;
                bus.s_eop[p] = 1'b0;
            end
        end
        @(negedge clk);
        if (bus.ff_valid) begin
            $display("ff   cyc=%0d data=%h sop=%b eop=%b empty=%0d",
                     cycle, bus.ff_data, bus.ff_sop, bus.ff_eop, bus.ff_empty);
            ff_cyc.push_back(cycle);
            if (exp_ff.size() == 0) chk("ff_unexpected", 1, 0);
            else begin
                w = exp_ff.pop_front();
                chk("ff_data", 64'(bus.ff_data), 64'(w.data));
                chk("ff_sop", 64'(bus.ff_sop), 64'(w.sop));
                chk("ff_eop", 64'(bus.ff_eop), 64'(w.eop));
                chk("ff_empty", 64'(bus.ff_empty), 64'(w.empty));
            end
        end
        if (bus.meta_valid) begin
            $display("meta cyc=%0d port=%0d sop=%b eop=%b empty=%0d",
                     cycle, bus.meta_port, bus.meta_sop, bus.meta_eop, bus.meta_empty);
            meta_cyc.push_back(cycle);
            if (exp_meta.size() == 0) chk("meta_unexpected", 1, 0);
            else begin
                w = exp_meta.pop_front();
                chk("meta_port", 64'(bus.meta_port), 64'(w.port));
                chk("meta_sop", 64'(bus.meta_sop), 64'(w.sop));
                chk("meta_eop", 64'(bus.meta_eop), 64'(w.eop));
                chk("meta_empty", 64'(bus.meta_empty), 64'(w.empty));
            end
        end
        acc = bus.s_valid & bus.s_ready;
        rdy_log.push_back(bus.s_ready);
        @(posedge clk);
        if (rst) begin
            src.delete(); exp_ff.delete(); exp_meta.delete();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    hi = head_idx(p);
                    w = src[hi];
                    src.delete(hi);
                    exp_ff.push_back(w);
                    exp_meta.push_back(w);
                    if (w.sop) sop_log.push_back(p);
                    xfer_cnt++;
                end
            end
        end
        #1;
        cycle++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    task automatic basic_pkt(input string tag);
        int c0;
        clear_logs();
        add_pkt(1, 3, 32'h0000_0100);
        c0 = cycle;
        run(10);
        chk({tag, "_ff_n"}, 64'(ff_cyc.size()), 3);
        chk({tag, "_meta_n"}, 64'(meta_cyc.size()), 3);
        if (ff_cyc.size() == 3 && meta_cyc.size() == 3) begin
            chk({tag, "_ff_first"}, 64'(ff_cyc[0] - c0), 2);
            chk({tag, "_ff_last"}, 64'(ff_cyc[2] - c0), 4);
            chk({tag, "_meta_first"}, 64'(meta_cyc[0] - c0), 4);
            chk({tag, "_meta_last"}, 64'(meta_cyc[2] - c0), 6);
        end
        chk({tag, "_rdy_grant_cyc"}, 64'(rdy_log[c0]), 0);
        chk({tag, "_rdy_xfer_cyc"}, 64'(rdy_log[c0+1]), 64'(4'b0010));
    endtask

    initial begin
        bus.s_data = '0; bus.s_valid = '0; bus.s_sop = '0; bus.s_eop = '0;
        bus.s_empty = '0; bus.credit_return = 1'b0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_s_ready", 64'(bus.s_ready), 0);
        chk("rst_ff_valid", 64'(bus.ff_valid), 0);
        chk("rst_meta_valid", 64'(bus.meta_valid), 0);
        chk("rst_credit_err", 64'(bus.credit_err), 0);

        // Single port, short packet: latency of grant, ff and metadata.
        auto_ret = 1'b1;
        basic_pkt("t1");

        // Round robin across ports with the inter-packet gap.
        do_reset();
        clear_logs();
        add_pkt(0, 2, 32'h0000_0200);
        add_pkt(2, 2, 32'h0000_0300);
        run(14);
        add_pkt(0, 1, 32'h0000_0400);
        add_pkt(3, 1, 32'h0000_0500);
        run(14);
        chk("rr_n", 64'(sop_log.size()), 4);
        if (sop_log.size() == 4) begin
            chk("rr_0", 64'(sop_log[0]), 0);
            chk("rr_1", 64'(sop_log[1]), 2);
            chk("rr_2", 64'(sop_log[2]), 3);
            chk("rr_3", 64'(sop_log[3]), 0);
        end
        if (ff_cyc.size() >= 3) chk("gap_cycles", 64'(ff_cyc[2] - ff_cyc[1]), 4);
        else chk("gap_ff_n", 64'(ff_cyc.size()), 6);

        // Credit exhaustion and one-at-a-time release.
        do_reset();
        auto_ret = 1'b0;
        clear_logs();
        add_pkt(0, 6, 32'h0000_0600);
        run(12);
        chk("cred_stall_n", 64'(ff_cyc.size()), 4);
        chk("cred_stall_rdy", 64'(rdy_log[cycle-1]), 0);
        cr = 1'b1; tick(); cr = 1'b0;
        run(6);
        chk("cred_one_more", 64'(ff_cyc.size()), 5);
        cr = 1'b1; tick(); cr = 1'b0;
        run(6);
        chk("cred_last", 64'(ff_cyc.size()), 6);
        for (int i = 0; i < CR; i++) begin
            cr = 1'b1; tick(); cr = 1'b0;
            run(2);
        end
        chk("err_before", 64'(bus.credit_err), 0);

        // Return into a full counter: sticky error, counter unchanged.
        cr = 1'b1; tick(); cr = 1'b0;
        run(2);
        chk("err_set", 64'(bus.credit_err), 1);
        clear_logs();
        add_pkt(1, 6, 32'h0000_0700);
        run(14);
        chk("err_sticky", 64'(bus.credit_err), 1);
        chk("err_cred_unchanged", 64'(ff_cyc.size()), 4);

        // Return coinciding with a transfer at credits=1.
        do_reset();
        chk("err_cleared", 64'(bus.credit_err), 0);
        clear_logs();
        add_pkt(2, 6, 32'h0000_0800);
        for (int i = 0; i < 20 && xfer_cnt < 3; i++) tick();
        chk("same_cyc_reach", 64'(xfer_cnt), 3);
        cr = 1'b1; tick(); cr = 1'b0;
        run(10);
        chk("same_cyc_n", 64'(ff_cyc.size()), 5);
        if (ff_cyc.size() == 5) chk("same_cyc_nostall", 64'(ff_cyc[4] - ff_cyc[3]), 1);

        // Reset in the middle of a packet, then a clean packet.
        do_reset();
        auto_ret = 1'b1;
        clear_logs();
        add_pkt(1, 4, 32'h0000_0900);
        for (int i = 0; i < 10 && xfer_cnt < 1; i++) tick();
        chk("mid_rst_reach", 64'(xfer_cnt), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_s_ready", 64'(bus.s_ready), 0);
        chk("mid_rst_ff_valid", 64'(bus.ff_valid), 0);
        chk("mid_rst_meta_valid", 64'(bus.meta_valid), 0);
        auto_ret = 1'b0;
        basic_pkt("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
